ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Read-side sequencer for the dual-port block RAM used across the design.
- Given a start command with base address and word count, drives the RAM's read-only port address, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream.
- Sits directly downstream of the RAM and upstream of any stream consumer (serialiser, display or UART feeder).
- Full throughput (1 word/cycle) when the consumer never stalls.

Parameters:
AddrSize, 8, RAM address width; also the width of base.
DataSize, 8, RAM word width; also the width of ram_data and out_data.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base  in  AddrSize  first RAM address to read.
- count  in  AddrSize+1  number of words to read, 0..2**AddrSize.
- busy  out  1  high from the cycle after start is accepted until the transfer completes.
- done  out  1  one-cycle completion pulse.
- ram_addr  out  AddrSize  to RAM addr1 (read port).
- ram_data  in  DataSize  from RAM data_o1. Valid the cycle after ram_addr is presented.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DataSize  stream word.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.

Reset (reset low, any time, including mid-transfer):
- All state cleared immediately: busy=0, done=0, out_valid=0, out_data=0, ram_addr=0, FIFO empty, in-flight flag clear.
- Data already requested from the RAM is discarded.

State machine, IDLE / READ / DRAIN:
- IDLE:
  - start=1 with count>0: latch base and count, go to READ.
  - start=1 with count=0: stay IDLE, pulse done next cycle, busy stays 0, no stream output.
- READ:
  - Issue one read per cycle while (FIFO occupancy + in-flight) < 3.
  - Issue means: drive ram_addr = current address, set in-flight, increment address, decrement remaining.
  - Go to DRAIN when remaining reaches 0.
- DRAIN:
  - Wait until in-flight is clear, the FIFO is empty and the last word has handshaken.
  - Then return to IDLE, pulse done for 1 cycle, drop busy in the same cycle.

Datapath and handshake:
- Address arithmetic is modulo 2**AddrSize, so base+count may wrap past the top address back to 0.
- In-flight flag:
  - Set in the cycle after an issue.
  - While set, ram_data is written into a 3-entry FIFO at the clock edge.
- out_valid = FIFO non-empty; out_data = FIFO head.
- A word transfers when out_valid & out_ready.
- A FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- The credit rule (occupancy + in-flight < 3) guarantees no overflow. An overflow write is a design error; the bench flags it with an assertion.
- start while busy is ignored; no queuing.
- ram_addr holds its last value when no read is issued.

Latency and throughput:
- start high in cycle 0:
  - busy=1 and ram_addr=base in cycle 1.
  - First out_valid in cycle 3.
- With out_ready held high, N words stream on N consecutive cycles, 3..N+2.
- done pulses in cycle N+3.

Test Plan:
1. RAM preloaded with mem[k]=k. start, base=0x10, count=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 in cycles 3-6; done=1 in cycle 7 only; busy low from cycle 7.
2. base=0xFE, count=4 -> ram_addr sequence FE,FF,00,01; out_data 0xFE,0xFF,0x00,0x01.
3. count=8 with out_ready toggling 1,0,0,1,...:
   - exactly 8 handshakes, data in order, no duplicates or losses;
   - out_data stable during stalls;
   - FIFO occupancy never exceeds 3.
4. count=0 -> done pulses in cycle 1; busy, out_valid and ram_addr activity stay 0.
5. Second start during a transfer of count=5 -> ignored; exactly 5 words, then a single done.
6. reset pulled low in cycle 4 of a count=16 transfer:
   - all outputs 0 asynchronously;
   - after release, a fresh start with base=0, count=2 yields exactly 0x00, 0x01.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequences block-RAM reads and presents the words as a valid/ready stream
module ram_stream_reader #(
    parameter int AddrSize = 8,
    parameter int DataSize = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AddrSize-1:0] base,
    input  logic [AddrSize:0]   count,
    output logic                busy,
    output logic                done,
    output logic [AddrSize-1:0] ram_addr,
    input  logic [DataSize-1:0] ram_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DataSize-1:0] out_data
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [AddrSize:0]   CntOne  = 1;
    localparam logic [AddrSize-1:0] AddrOne = 1;
    state_t              state_q, state_d;
    logic [AddrSize-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [AddrSize:0]   rem_q, rem_d;
    logic                req_q, req_d, infl_q, infl_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]          occ_q, occ_d, wr_q, wr_d, rd_q, rd_d;
    logic [DataSize-1:0] mem_q [3];
    logic [DataSize-1:0] mem_d [3];
    logic                push, pop;
    logic [2:0]          pending;

    // FIFO bookkeeping: capture returning RAM data, release the head on handshake
    always_comb begin
        push    = infl_q;
        pop     = (occ_q != 2'd0) && out_ready;
        occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
        wr_d    = push ? (wr_q == 2'd2 ? 2'd0 : wr_q + 2'd1) : wr_q;
        rd_d    = pop ? (rd_q == 2'd2 ? 2'd0 : rd_q + 2'd1) : rd_q;
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = ram_data;
        infl_d  = req_q;
        pending = {1'b0, occ_q} + {2'b0, req_q} + {2'b0, infl_q} - {2'b0, pop};
    end

    // Sequencer: the first read is issued on the accepting edge so ram_addr=base in the next cycle
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        ram_addr_d = ram_addr_q;
        req_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && count == '0) begin
                    done_d = 1'b1;
                end else if (start) begin
                    ram_addr_d = base;
                    addr_d     = base + AddrOne;
                    rem_d      = count - CntOne;
                    req_d      = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = (count == CntOne) ? DRAIN : READ;
                end
            end
            READ: begin
                if (pending < 3'd3) begin
                    ram_addr_d = addr_q;
                    addr_d     = addr_q + AddrOne;
                    rem_d      = rem_q - CntOne;
                    req_d      = 1'b1;
                    state_d    = (rem_q == CntOne) ? DRAIN : READ;
                end
            end
            DRAIN: begin
                if (!req_q && !infl_q && occ_d == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards everything including reads still in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            ram_addr_q <= '0;
            req_q      <= 1'b0;
            infl_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            occ_q      <= 2'd0;
            wr_q       <= 2'd0;
            rd_q       <= 2'd0;
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            ram_addr_q <= ram_addr_d;
            req_q      <= req_d;
            infl_q     <= infl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            occ_q      <= occ_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            for (int i = 0; i < 3; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_addr  = ram_addr_q;
    assign out_valid = occ_q != 2'd0;
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized bench checking the stream against a queue-based reference
module tb_ram_stream_reader;
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base;
    logic [8:0] count;
    logic       busy, done, out_valid, out_ready;
    logic [7:0] ram_addr, ram_data, out_data;
    logic [7:0] mem [256];
    int         checks = 0;
    int         failures = 0;

    ram_stream_reader #(.AddrSize(8), .DataSize(8)) dut (
        .clock(clock), .reset(reset), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_data(ram_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    // Registered-read RAM: data for an address appears the cycle after it is presented
    always @(posedge clock) ram_data <= mem[ram_addr];

    // A FIFO write with no free slot and no pop would lose data
    always @(negedge clock)
        if (reset)
            assert (!(dut.infl_q && dut.occ_q == 2'd3 && !(out_valid && out_ready)))
            else $error("FAIL overflow write into full fifo");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high (cycle-exact checks), 1: ready 1,0,0 repeating, 2: random ready
    task automatic xfer(input logic [7:0] b, input int n, input int mode, input bit dbl);
        logic [7:0] q[$];
        int got, ndone, done_cyc, cyc;
        bit pv, pr;
        for (int i = 0; i < n; i++) q.push_back(mem[8'(b + i)]);
        got = 0; ndone = 0; done_cyc = -1; pv = 0; pr = 0;
        @(posedge clock); #1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            start     = (cyc == 0) || (dbl && cyc == 2);
            base      = (cyc == 0) ? b : b ^ 8'h55;
            count     = (cyc == 0) ? 9'(n) : 9'd3;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (pv && !pr) check("hold_valid", out_valid, 1);
            if (mode == 0 && n > 0) check("valid_timing", out_valid, (cyc >= 3 && cyc < n + 3));
            if (mode == 0 && cyc >= 1 && cyc <= n) check("ram_addr", ram_addr, 8'(b + cyc - 1));
            if (out_valid) begin
                if (q.size() == 0) check("extra_word", q.size(), 1);
                else begin
                    check("data", out_data, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (n == 0) begin
                check("busy_zero", busy, 0);
                check("valid_zero", out_valid, 0);
                check("addr_zero", ram_addr, 0);
            end
            if (done_cyc < 0 && n > 0 && cyc >= 1 && !done) check("busy", busy, 1);
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_at_done", busy, 0);
                    check("words_at_done", got, n);
                    if (mode == 0) check("done_cycle", cyc, n == 0 ? 1 : n + 3);
                end
            end
            pv = out_valid;
            pr = out_ready;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clock); #1;
        end
        check("done_seen", done_cyc >= 0, 1);
        check("done_count", ndone, 1);
        check("words", got, n);
        check("idle_busy", busy, 0);
        start = 0;
    endtask

    initial begin
        reset = 0; start = 0; base = 0; count = 0; out_ready = 0;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        repeat (2) @(posedge clock);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", out_data, 0);
        reset = 1;
        xfer(8'h00, 0, 0, 0);
        xfer(8'h10, 4, 0, 0);
        xfer(8'hFE, 4, 0, 0);
        xfer(8'h40, 8, 1, 0);
        xfer(8'h30, 5, 0, 1);
        @(posedge clock); #1;
        start = 1; base = 8'h20; count = 9'd16; out_ready = 1;
        @(posedge clock); #1;
        start = 0;
        repeat (3) @(posedge clock);
        #2;
        check("pre_rst_valid", out_valid, 1);
        reset = 0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_valid", out_valid, 0);
        check("async_addr", ram_addr, 0);
        check("async_data", out_data, 0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1;
        xfer(8'h00, 2, 0, 0);
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        for (int t = 0; t < 6; t++) xfer(8'($urandom), int'($urandom_range(1, 40)), 2, 0);
        xfer(8'($urandom), 20, 1, 1);
        xfer(8'($urandom), 256, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
